// File: rtl/z88_mem_arbiter_if.sv
// Bus bundle between the arbiter and its neighbours: the Z80 request
// path (after blink segment translation), the LCD refresh fetcher and the
// physical memory bus toward the slot chip-enable decode.
interface z88_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [21:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wait_n;
  logic        lcd_req;
  logic [21:0] lcd_addr;
  logic        lcd_ack;
  logic [7:0]  lcd_rdata;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        lcd_owner;

  // Requesters and memory side drive the arbiter.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, lcd_req, lcd_addr, mem_rdata,
    input  cpu_wait_n, lcd_ack, lcd_rdata, mem_addr, mem_wdata, mem_oe_n,
           mem_we_n, lcd_owner
  );

  // The arbiter itself.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, lcd_req, lcd_addr, mem_rdata,
    output cpu_wait_n, lcd_ack, lcd_rdata, mem_addr, mem_wdata, mem_oe_n,
           mem_we_n, lcd_owner
  );
endinterface

// File: rtl/z88_mem_arbiter.sv
// Z88 memory arbiter: shares the 22-bit physical bus between the Z80 and
// the LCD refresh fetcher. The Z80 has priority with zero added latency;
// an LCD fetch pending for MAX_WAIT cycles takes the next IDLE slot and the
// Z80 is held off via cpu_wait_n for the duration.
module z88_mem_arbiter #(
  parameter int LCD_CYC  = 3,
  parameter int MAX_WAIT = 12
) (
  input logic              mck,
  input logic              rin,
  z88_mem_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int CW = $clog2(LCD_CYC + 1);

  typedef enum logic [1:0] {IDLE, CPU_ACC, LCD_ACC} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [CW-1:0] acc_cnt;
  logic [21:0]   addr_q;
  logic [21:0]   addr_hold;
  logic          starve;
  logic          cpu_grant;
  logic          lcd_grant;
  logic          lcd_acc;

  assign starve    = (wait_cnt == WW'(MAX_WAIT));
  // Reset gates the grants so nothing reaches the bus while rin is high.
  assign cpu_grant = !rin && ((state == CPU_ACC) ||
                              (state == IDLE && bus.cpu_req && !starve));
  assign lcd_grant = (state == IDLE) && bus.lcd_req && !(bus.cpu_req && !starve);
  assign lcd_acc   = !rin && (state == LCD_ACC);

  assign bus.lcd_owner  = lcd_acc;
  assign bus.mem_wdata  = bus.cpu_wdata;
  assign bus.cpu_wait_n = rin || !(bus.cpu_req && !cpu_grant);

  // Arbitration FSM; lcd_ack/lcd_rdata are registered here.
  always_ff @(posedge mck) begin
    if (rin) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      addr_q    <= '0;
      bus.lcd_ack   <= 1'b0;
      bus.lcd_rdata <= '0;
    end else begin
      bus.lcd_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req && !starve) begin
            state <= CPU_ACC;
          end else if (bus.lcd_req) begin
            state   <= LCD_ACC;
            addr_q  <= bus.lcd_addr;
            acc_cnt <= '0;
          end
        end
        // Dropping back to IDLE leaves one arbitration slot between Z80 accesses.
        CPU_ACC: if (!bus.cpu_req) state <= IDLE;
        LCD_ACC: begin
          acc_cnt <= acc_cnt + CW'(1);
          if (acc_cnt == CW'(LCD_CYC - 1)) begin
            bus.lcd_rdata <= bus.mem_rdata;
            bus.lcd_ack   <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation counter: counts cycles an LCD request sits un-granted.
  always_ff @(posedge mck) begin
    if (rin || !bus.lcd_req || lcd_grant) wait_cnt <= '0;
    else if (state != LCD_ACC && !starve) wait_cnt <= wait_cnt + WW'(1);
  end

  // Last driven address, so an idle bus keeps its previous address.
  always_ff @(posedge mck) begin
    if (rin) addr_hold <= '0;
    else     addr_hold <= bus.mem_addr;
  end

  // Bus mux: Z80 path is combinational so a granted access sees no delay.
  always_comb begin
    bus.mem_oe_n = 1'b1;
    bus.mem_we_n = 1'b1;
    bus.mem_addr = rin ? 22'd0 : addr_hold;
    if (cpu_grant) begin
      bus.mem_addr = bus.cpu_addr;
      bus.mem_oe_n = bus.cpu_we;
      bus.mem_we_n = !bus.cpu_we;
    end else if (lcd_acc) begin
      bus.mem_addr = addr_q;
      bus.mem_oe_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_z88_mem_arbiter.sv
// Directed bench for z88_mem_arbiter: a per-cycle vector table for the
// single-access cases, plus scripted starvation and reset-abort sequences.
module tb_z88_mem_arbiter;
  localparam logic [21:0] AC = 22'h01_2345;
  localparam logic [21:0] AL = 22'h08_0100;
  localparam logic [21:0] AW = 22'h20_0010;

  typedef struct {
    logic r, cq, cw; logic [21:0] ca; logic [7:0] cd;
    logic lq; logic [21:0] la; logic [7:0] md;
    logic ew, eoe, ewe, eown, eack; logic [7:0] erd; logic [21:0] ea;
  } vec_t;

  logic mck = 1'b0;
  logic rin = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   both_low = 0;
  vec_t vecs[$];

  z88_mem_arbiter_if bus();

  z88_mem_arbiter #(.LCD_CYC(3), .MAX_WAIT(12)) dut (
    .mck(mck), .rin(rin), .bus(bus.slave)
  );

  always #5 mck = ~mck;

  // Strobe exclusivity watched on every sample point.
  always @(negedge mck) if (!bus.mem_oe_n && !bus.mem_we_n) both_low++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, cq, cw, input logic [21:0] ca, input logic [7:0] cd,
                     input logic lq, input logic [21:0] la, input logic [7:0] md,
                     input logic ew, eoe, ewe, eown, eack,
                     input logic [7:0] erd, input logic [21:0] ea);
    vec_t v;
    v.r = r; v.cq = cq; v.cw = cw; v.ca = ca; v.cd = cd;
    v.lq = lq; v.la = la; v.md = md;
    v.ew = ew; v.eoe = eoe; v.ewe = ewe; v.eown = eown; v.eack = eack;
    v.erd = erd; v.ea = ea;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, cq, cw, input logic [21:0] ca, input logic [7:0] cd,
                       input logic lq, input logic [21:0] la, input logic [7:0] md);
    rin = r; bus.cpu_req = cq; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.lcd_req = lq; bus.lcd_addr = la; bus.mem_rdata = md;
  endtask

  initial begin
    int stall, first_own, ack_cyc, resume;
    logic [7:0] rd_ack;
    logic [34:0] act, exp;

    //  r  cq cw ca  cd     lq la  md      wn oe we own ack erd    ea
    // reset with both requesters active
    add(1, 1, 0, AC, 8'h00, 1, AL, 8'h5A,  1, 1, 1, 0, 0, 8'h00, 22'h0);
    add(1, 1, 0, AC, 8'h00, 1, AL, 8'h5A,  1, 1, 1, 0, 0, 8'h00, 22'h0);
    // lone LCD fetch: 3 cycles owned, ack next cycle with data
    add(0, 0, 0, AC, 8'h00, 1, AL, 8'h5A,  1, 1, 1, 0, 0, 8'h00, 22'h0);
    add(0, 0, 0, AC, 8'h00, 1, AL, 8'h5A,  1, 0, 1, 1, 0, 8'h00, AL);
    add(0, 0, 0, AC, 8'h00, 1, AL, 8'h5A,  1, 0, 1, 1, 0, 8'h00, AL);
    add(0, 0, 0, AC, 8'h00, 1, AL, 8'h5A,  1, 0, 1, 1, 0, 8'h00, AL);
    add(0, 0, 0, AC, 8'h00, 0, AL, 8'h5A,  1, 1, 1, 0, 1, 8'h5A, AL);
    add(0, 0, 0, AC, 8'h00, 0, AL, 8'h5A,  1, 1, 1, 0, 0, 8'h5A, AL);
    // simultaneous requests: Z80 first, LCD in the IDLE slot after it drops
    add(0, 1, 0, AC, 8'h00, 1, AL, 8'h5A,  1, 0, 1, 0, 0, 8'h5A, AC);
    add(0, 1, 0, AC, 8'h00, 1, AL, 8'h5A,  1, 0, 1, 0, 0, 8'h5A, AC);
    add(0, 0, 0, AC, 8'h00, 1, AL, 8'h5A,  1, 0, 1, 0, 0, 8'h5A, AC);
    add(0, 0, 0, AC, 8'h00, 1, AL, 8'h5A,  1, 1, 1, 0, 0, 8'h5A, AC);
    add(0, 0, 0, AC, 8'h00, 1, AL, 8'h3C,  1, 0, 1, 1, 0, 8'h5A, AL);
    add(0, 0, 0, AC, 8'h00, 1, AL, 8'h3C,  1, 0, 1, 1, 0, 8'h5A, AL);
    add(0, 0, 0, AC, 8'h00, 1, AL, 8'h3C,  1, 0, 1, 1, 0, 8'h5A, AL);
    add(0, 0, 0, AC, 8'h00, 0, AL, 8'h3C,  1, 1, 1, 0, 1, 8'h3C, AL);
    // Z80 write, zero wait
    add(0, 1, 1, AW, 8'hA5, 0, AL, 8'h3C,  1, 1, 0, 0, 0, 8'h3C, AW);
    add(0, 1, 1, AW, 8'hA5, 0, AL, 8'h3C,  1, 1, 0, 0, 0, 8'h3C, AW);
    add(0, 0, 1, AW, 8'hA5, 0, AL, 8'h3C,  1, 1, 0, 0, 0, 8'h3C, AW);
    add(0, 0, 0, AW, 8'hA5, 0, AL, 8'h3C,  1, 1, 1, 0, 0, 8'h3C, AW);
    // Z80 arrives while the LCD owns the bus: stalled until the slot frees
    add(0, 0, 0, AC, 8'h00, 1, AL, 8'h3C,  1, 1, 1, 0, 0, 8'h3C, AW);
    add(0, 1, 0, AC, 8'h00, 1, AL, 8'h3C,  0, 0, 1, 1, 0, 8'h3C, AL);
    add(0, 1, 0, AC, 8'h00, 1, AL, 8'h3C,  0, 0, 1, 1, 0, 8'h3C, AL);
    add(0, 1, 0, AC, 8'h00, 1, AL, 8'h3C,  0, 0, 1, 1, 0, 8'h3C, AL);
    add(0, 1, 0, AC, 8'h00, 0, AL, 8'h3C,  1, 0, 1, 0, 1, 8'h3C, AC);
    add(0, 0, 0, AC, 8'h00, 0, AL, 8'h3C,  1, 0, 1, 0, 0, 8'h3C, AC);
    add(0, 0, 0, AC, 8'h00, 0, AL, 8'h3C,  1, 1, 1, 0, 0, 8'h3C, AC);

    drive(1, 0, 0, 22'h0, 8'h00, 0, 22'h0, 8'h00);
    repeat (2) @(posedge mck);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].cq, vecs[i].cw, vecs[i].ca, vecs[i].cd,
            vecs[i].lq, vecs[i].la, vecs[i].md);
      @(negedge mck);
      act = {bus.cpu_wait_n, bus.mem_oe_n, bus.mem_we_n, bus.lcd_owner, bus.lcd_ack,
             bus.lcd_rdata, bus.mem_addr};
      exp = {vecs[i].ew, vecs[i].eoe, vecs[i].ewe, vecs[i].eown, vecs[i].eack,
             vecs[i].erd, vecs[i].ea};
      chk($sformatf("vec%0d{wait_n,oe_n,we_n,owner,ack,rdata,addr}", i), 64'(act), 64'(exp));
      if (vecs[i].cw) chk($sformatf("vec%0d_wdata", i), 64'(bus.mem_wdata), 64'h A5);
      @(posedge mck);
      #1;
    end

    // Starvation: Z80 reads of 2 cycles with 1-cycle gaps, LCD held.
    // wait_cnt reaches 12 during cycle 11; cycle 12 is the IDLE slot the LCD
    // takes. The Z80 stalls in that slot plus the 3 LCD cycles.
    stall = 0; first_own = -1; ack_cyc = -1; resume = 0; rd_ack = 8'h00;
    for (int c = 0; c < 19; c++) begin
      drive(0, (c < 12) ? ((c % 3) != 2) : (c < 18), 0, AC, 8'h00,
            (c < 16), 22'h08_0200, 8'hC3);
      @(negedge mck);
      if (!bus.cpu_wait_n) stall++;
      if (bus.lcd_owner && first_own < 0) first_own = c;
      if (bus.lcd_ack) begin ack_cyc = c; rd_ack = bus.lcd_rdata; end
      if (c == 16) resume = bus.cpu_wait_n ? 1 : 0;
      @(posedge mck);
      #1;
    end
    chk("starve_stall_cycles", 64'(stall), 64'd4);
    chk("starve_first_owner_cycle", 64'(first_own), 64'd13);
    chk("starve_ack_cycle", 64'(ack_cyc), 64'd16);
    chk("starve_ack_rdata", 64'(rd_ack), 64'hC3);
    chk("starve_z80_resumes", 64'(resume), 64'd1);

    // Reset on the 2nd cycle of an LCD access aborts it with no ack.
    drive(0, 0, 0, AC, 8'h00, 1, 22'h08_0300, 8'h77);
    @(posedge mck); #1;
    @(negedge mck);
    chk("abort_owner_before", 64'(bus.lcd_owner), 64'd1);
    @(posedge mck); #1;
    rin = 1'b1;
    @(negedge mck);
    chk("abort_ack_in_reset", 64'(bus.lcd_ack), 64'd0);
    @(posedge mck); #1;
    drive(0, 0, 0, AC, 8'h00, 0, 22'h08_0300, 8'h77);
    @(negedge mck);
    chk("abort_strobes_high", 64'({bus.mem_oe_n, bus.mem_we_n}), 64'h3);
    chk("abort_owner_after", 64'(bus.lcd_owner), 64'd0);
    chk("abort_wait_cnt", 64'(dut.wait_cnt), 64'd0);
    begin
      int acks = 0;
      for (int c = 0; c < 5; c++) begin
        if (bus.lcd_ack) acks++;
        @(posedge mck); #1;
        @(negedge mck);
      end
      chk("abort_no_ack", 64'(acks), 64'd0);
    end

    chk("strobe_exclusive", 64'(both_low), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
